// File: rtl/xor_hash_pkg.sv
// Shared constants, state encoding and the reference fold for the XOR hash checker.
package xor_hash_pkg;
  localparam int HASH_W      = 8;
  localparam int BLOCK_BITS  = 512;
  localparam int BLOCK_BYTES = BLOCK_BITS / HASH_W;
  localparam int CNT_W       = 6;

  typedef enum logic [1:0] {
    ST_DATA   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  // Byte k occupies bits [8k+7:8k]; the hash is the XOR of every byte.
  function automatic logic [HASH_W-1:0] fold_block(input logic [BLOCK_BITS-1:0] blk);
    logic [HASH_W-1:0] h;
    h = '0;
    for (int k = 0; k < BLOCK_BYTES; k++) begin
      h = h ^ blk[k*HASH_W +: HASH_W];
    end
    return h;
  endfunction
endpackage

// File: rtl/xor_hash_checker_acc.sv
// Running XOR accumulator: clr loads zero and wins over en, which folds din in.
module xor_fold_acc #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] acc
);
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc ^ din;
    end
  end
endmodule

// File: rtl/xor_hash_checker.sv
// Receive-side XOR hash checker: folds a block of payload bytes, then compares
// the fold against the trailing hash byte and reports the verdict.
//
//   state     | meaning
//   ST_DATA   | accepting payload bytes, cnt counts them
//   ST_CHECK  | next accepted byte is the transmitted hash
//   ST_REPORT | one-cycle done pulse, input stalled
module xor_hash_checker
  import xor_hash_pkg::*;
#(
  parameter int BLOCK_BYTES = xor_hash_pkg::BLOCK_BYTES,
  parameter int HASH_W      = xor_hash_pkg::HASH_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [HASH_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              done,
  output logic              match,
  output logic [HASH_W-1:0] hash_out,
  output logic              busy
);
  localparam int CW = $clog2(BLOCK_BYTES);
  localparam logic [CW-1:0] LAST = CW'(BLOCK_BYTES - 1);

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q;
  logic [HASH_W-1:0] acc;
  logic              accept;
  logic              acc_clr, acc_en;
  logic              hash_take;

  assign in_ready = (state_q != ST_REPORT);
  assign done     = (state_q == ST_REPORT);
  assign busy     = (state_q == ST_DATA && cnt_q != '0) || (state_q == ST_CHECK);
  // clear outranks acceptance, so a byte alongside clear never lands anywhere.
  assign accept   = in_valid && in_ready && !clear;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_DATA;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_clr   = 1'b0;
    acc_en    = 1'b0;
    hash_take = 1'b0;
    if (clear) begin
      state_d = ST_DATA;
      acc_clr = 1'b1;
    end else begin
      case (state_q)
        ST_DATA: begin
          acc_en = accept;
          if (accept && cnt_q == LAST) state_d = ST_CHECK;
        end
        ST_CHECK: begin
          if (accept) begin
            hash_take = 1'b1;
            acc_clr   = 1'b1;
            state_d   = ST_REPORT;
          end
        end
        ST_REPORT: state_d = ST_DATA;
        default:   state_d = ST_DATA;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (state_q == ST_DATA && accept) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  // Verdict registers survive clear; only rst or a new report changes them.
  always_ff @(posedge clk) begin
    if (rst) begin
      match    <= 1'b0;
      hash_out <= '0;
    end else if (hash_take) begin
      match    <= (acc == in_data);
      hash_out <= acc;
    end
  end

  xor_fold_acc #(.W(HASH_W)) u_acc (
    .clk (clk),
    .rst (rst),
    .clr (acc_clr),
    .en  (acc_en),
    .din (in_data),
    .acc (acc)
  );
endmodule

// File: tb/tb_xor_hash_checker.sv
// Directed bench for xor_hash_checker: a vector table of whole frames plus
// hand-written gap, clear and reset-in-CHECK sequences.
module tb_xor_hash_checker;
  import xor_hash_pkg::*;

  logic        clk = 1'b0;
  logic        rst, clear, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, done, match, busy;
  logic [7:0]  hash_out;

  int nvec = 0;
  int nmis = 0;
  int done_cnt = 0;

  typedef struct {
    logic [511:0] blk;
    logic [7:0]   hash;
    logic         exp_match;
    logic [7:0]   exp_hash;
  } vec_t;

  vec_t vt[5];

  xor_hash_checker dut (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .done     (done),
    .match    (match),
    .hash_out (hash_out),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done) done_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic put(input logic [7:0] b, input bit gaps);
    int g;
    if (gaps) begin
      g = 0;
      while ($urandom_range(0, 9) < 3 && g < 6) begin
        in_valid = 1'b0;
        in_data  = 8'hEE;
        @(negedge clk);
        g++;
      end
    end
    in_data  = b;
    in_valid = 1'b1;
    g = 0;
    while (!in_ready && g < 8) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) chk("ready_timeout", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_payload(input logic [511:0] blk, input bit gaps);
    for (int k = 0; k < 64; k++) put(blk[k*8 +: 8], gaps);
  endtask

  // Full frame and report check; entry and exit at a negedge.
  task automatic run_frame(input string tag, input logic [511:0] blk, input logic [7:0] h,
                           input logic em, input logic [7:0] eh, input bit gaps);
    int d0;
    d0 = done_cnt;
    send_payload(blk, gaps);
    chk({tag, "_check_busy"}, {31'd0, busy}, 32'd1);
    chk({tag, "_no_early_done"}, {31'd0, done}, 32'd0);
    put(h, gaps);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_ready_low"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_match"}, {31'd0, match}, {31'd0, em});
    chk({tag, "_hash"}, {24'd0, hash_out}, {24'd0, eh});
    @(negedge clk);
    chk({tag, "_done_1cyc"}, {31'd0, done}, 32'd0);
    chk({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    chk({tag, "_one_pulse"}, done_cnt - d0, 32'd1);
  endtask

  initial begin
    logic [511:0] b;
    int d0;

    b = '0;
    vt[0] = '{b, 8'h00, 1'b1, 8'h00};
    for (int k = 0; k < 64; k++) b[k*8 +: 8] = 8'(k);
    vt[1] = '{b, 8'h00, 1'b1, 8'h00};
    vt[2] = '{b, 8'hFF, 1'b0, 8'h00};
    b = '0; b[7:0] = 8'hA5;
    vt[3] = '{b, 8'h5A, 1'b0, 8'hA5};
    b = '0; b[7:0] = 8'h01; b[511:504] = 8'h80;
    vt[4] = '{b, 8'h81, 1'b1, 8'h81};

    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_match", {31'd0, match}, 32'd0);
    chk("rst_hash", {24'd0, hash_out}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 5; i++)
      run_frame($sformatf("vec%0d", i), vt[i].blk, vt[i].hash, vt[i].exp_match, vt[i].exp_hash, 1'b0);

    // Same single-A5 frame with random gaps; hash now correct.
    run_frame("gaps", vt[3].blk, 8'hA5, 1'b1, 8'hA5, 1'b1);

    // Abort mid-block; the byte offered with clear must be dropped.
    d0 = done_cnt;
    for (int k = 0; k < 20; k++) put(8'hFF, 1'b0);
    chk("pre_clear_busy", {31'd0, busy}, 32'd1);
    in_data = 8'hFF; in_valid = 1'b1; clear = 1'b1;
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0;
    chk("clear_busy", {31'd0, busy}, 32'd0);
    chk("clear_no_done", done_cnt - d0, 32'd0);
    chk("clear_keep_match", {31'd0, match}, 32'd1);
    chk("clear_keep_hash", {24'd0, hash_out}, 32'h0A5);
    b = '0;
    for (int k = 0; k < 64; k++) b[k*8 +: 8] = 8'h11;
    run_frame("after_clear", b, 8'h00, 1'b1, 8'h00, 1'b0);

    // Reset while the hash byte is presented in CHECK.
    b = '0;
    for (int k = 0; k < 64; k++) b[k*8 +: 8] = 8'h01;
    send_payload(b, 1'b0);
    chk("rstchk_in_check", {31'd0, busy}, 32'd1);
    d0 = done_cnt;
    in_data = 8'h00; in_valid = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("rstchk_no_done", done_cnt - d0, 32'd0);
    chk("rstchk_done", {31'd0, done}, 32'd0);
    chk("rstchk_match", {31'd0, match}, 32'd0);
    chk("rstchk_hash", {24'd0, hash_out}, 32'd0);
    chk("rstchk_busy", {31'd0, busy}, 32'd0);
    chk("rstchk_ready", {31'd0, in_ready}, 32'd1);
    run_frame("after_rst", b, 8'h00, 1'b1, 8'h00, 1'b0);

    // The package model must agree with the DUT on a non-trivial block.
    b = '0;
    for (int k = 0; k < 64; k++) b[k*8 +: 8] = 8'(k * 7 + 3);
    run_frame("model", b, fold_block(b), 1'b1, fold_block(b), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/xor_hash_checker.md
Name: xor_hash_checker

Overview:
- Receive-side counterpart of the 512-bit XOR hash generator.
- Accepts a streamed 512-bit block as 64 bytes, then one expected-hash byte.
- Folds the block into an 8-bit running XOR and reports whether the computed hash equals the transmitted one.
- Sits between a byte-wide link receiver and the message consumer; uses a valid/ready byte handshake.

Parameters:
- BLOCK_BYTES, 64, number of payload bytes per block (512 bits / 8).
- HASH_W, 8, hash and byte width in bits.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  synchronous abort; discards the partial block.
- in_data  in  HASH_W  payload or hash byte.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  checker can accept a byte this cycle.
- done  out  1  one-cycle pulse; the result is valid.
- match  out  1  1 = computed hash equals received hash; held until the next done.
- hash_out  out  HASH_W  computed hash; held until the next done.
- busy  out  1  at least one payload byte has been accepted and the block is not yet reported.

Behaviour:
- Hash definition: XOR of all 64 payload bytes. Byte k carries block bits [8k+7:8k]. Byte 0 (bits 7:0) is sent first.
- Transfer rule: a byte is accepted when in_valid && in_ready at a rising edge. in_data is ignored otherwise.
- Reset (rst=1): state=DATA, acc=0, cnt=0, done=0, match=0, hash_out=0, busy=0. in_ready=1 after reset.
- State DATA:
  - in_ready=1.
  - Each accepted byte: acc <= acc ^ in_data; cnt <= cnt+1.
  - Accepting byte with cnt==BLOCK_BYTES-1 moves to CHECK. cnt wraps to 0.
- State CHECK:
  - in_ready=1.
  - The accepted byte is the expected hash.
  - Registers: match <= (acc==in_data); hash_out <= acc; done <= 1; acc <= 0. Goes to REPORT.
- State REPORT:
  - Lasts one cycle; in_ready=0; done=1 during it.
  - Returns to DATA.
  - Latency: done is high exactly one cycle after the hash byte is accepted.
- cnt is 6 bits, cleared on rst/clear/end of block. It never exceeds 63.
- busy = (state==DATA && cnt!=0) || state==CHECK.
- clear:
  - Returns to DATA with acc=0, cnt=0; no done is produced.
  - match and hash_out keep their last reported values.
  - A byte presented in the same cycle as clear is dropped.
- rst has priority over clear; clear has priority over byte acceptance.
- in_valid held high with no gaps: a 65-byte frame completes every 66 cycles, because REPORT inserts one stall cycle.
- in_valid gaps: any number of idle cycles between bytes is legal. State, cnt and acc hold.

Decomposition:
- Shared package `xor_hash_pkg`:
  - HASH_W=8, BLOCK_BITS=512, BLOCK_BYTES=64, CNT_W=6.
  - State enum {ST_DATA, ST_CHECK, ST_REPORT}.
  - Function fold_block(512-bit) -> 8-bit, the reference model for the bench.
- One natural sub-module: `xor_fold_acc`, the 8-bit accumulator with load-zero/xor-enable. Control FSM and counter stay in the top.

Test Plan:
- 64 bytes of 0x00, hash byte 0x00 -> done pulses one cycle after the hash byte; match=1; hash_out=0x00.
- Bytes 0x00..0x3F in order, hash byte 0x00 -> match=1 (XOR of 0..63 is 0); then a second identical frame, hash 0xFF -> match=0, hash_out=0x00.
- Byte0=0xA5, bytes1..63=0x00, hash 0x5A -> match=0, hash_out=0xA5; in_ready=0 in the done cycle only.
- Same 0xA5 frame, in_valid toggled randomly (30% gaps), hash 0xA5 -> match=1. Done is still exactly one pulse, one cycle after the hash accept.
- Send 20 bytes of 0xFF, pulse clear, then a full frame of 0x11 with hash 0x00 -> done=1, match=1 (64 × 0x11 XORs to 0). No done was produced for the aborted frame; busy=0 immediately after clear.
- rst asserted in CHECK with the hash byte present -> no done; all outputs 0; the next frame of 64 × 0x01 with hash 0x00 -> match=1.
